ahb_lite_master: RTL and testbench

- Single-outstanding AHB-Lite master bridge. Sits directly upstream of the AHB slave wrapper and its address decoder.
- Converts a simple valid/ready request port from the core (fetch/LSU) into AHB NONSEQ single transfers.
- Handles HREADY wait states and two-cycle ERROR/RETRY/SPLIT responses.
- Returns one registered response per request.

---
 rtl/ahb_pkg.sv | 30 +++
 rtl/ahb_lite_master.sv | 169 ++++++++++++++++
 tb/tb_ahb_lite_master.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the master bridge and slave wrapper.
//   - HTRANS codes (T_IDLE/T_BUSY/T_NONSEQ/T_SEQ)
//   - HRESP codes (OKAY/ERROR/RETRY/SPLIT)
//   - HSIZE codes (SZ_BYTE/SZ_HALF/SZ_WORD)
//   - master FSM state encoding
package ahb_pkg;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;
  localparam logic [1:0] RETRY = 2'b10;
  localparam logic [1:0] SPLIT = 2'b11;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_ERR2  = 3'd3,
    ST_RTRY2 = 3'd4
  } mst_state_e;

endpackage

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-outstanding AHB-Lite master bridge.
// Turns a valid/ready core request into one NONSEQ single transfer, absorbs
// HREADY wait states and the two-cycle ERROR/RETRY/SPLIT responses, and
// returns one registered response pulse per request. All outputs registered.
//
// Ports:
//   H_clk, H_reset        clock, synchronous active-high reset
//   req_*                 core request (valid/ready, write, size, addr, wdata)
//   resp_*                one-cycle response (valid, err, rdata)
//   H_addr/H_trans/H_write/H_size/H_wdata   AHB master outputs
//   H_ready/H_resp/H_rdata                  AHB slave-mux inputs
//
// Optional: define AHB_MST_TIMEOUT_EN to add a wait-state watchdog that
// aborts a transfer after TIMEOUT_CYC consecutive H_ready=0 cycles.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              H_clk,
  input  logic              H_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] H_addr,
  output logic [1:0]        H_trans,
  output logic              H_write,
  output logic [2:0]        H_size,
  output logic [DATA_W-1:0] H_wdata,
  input  logic              H_ready,
  input  logic [1:0]        H_resp,
  input  logic [DATA_W-1:0] H_rdata
);

  mst_state_e        r_state, w_state_nxt;
  logic              r_req_ready;
  // Request latch doubles as the AHB address-phase drivers: the address
  // signals only ever carry the latched request, so a retry re-issues it as is.
  logic              r_req_write;
  logic [2:0]        r_req_size;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_wdata;
  logic [1:0]        r_htrans;
  logic [DATA_W-1:0] r_hwdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic w_accept;
  logic w_fire;
  logic w_fire_err;
  logic w_timeout;

  assign w_accept = req_valid & r_req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_fire_err  = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ADDR;
      ST_ADDR:  if (H_ready) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (H_ready) begin
          // A non-OKAY response with H_ready=1 is a protocol violation;
          // completing it as an error is the safe interpretation.
          w_state_nxt = ST_IDLE;
          w_fire      = 1'b1;
          w_fire_err  = (H_resp != OKAY);
        end else if (H_resp == ERROR) begin
          w_state_nxt = ST_ERR2;
        end else if (H_resp == RETRY || H_resp == SPLIT) begin
          w_state_nxt = ST_RTRY2;
        end
      end
      ST_ERR2: begin
        if (H_ready) begin
          w_state_nxt = ST_IDLE;
          w_fire      = 1'b1;
          w_fire_err  = 1'b1;
        end
      end
      ST_RTRY2: if (H_ready) w_state_nxt = ST_ADDR;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_fire      = 1'b1;
      w_fire_err  = 1'b1;
    end
  end

  always_ff @(posedge H_clk) begin
    if (H_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Registered outputs are computed from the next state so they line up
  // with the state they belong to.
  always_ff @(posedge H_clk) begin
    if (H_reset) begin
      r_req_ready  <= 1'b1;
      r_req_write  <= 1'b0;
      r_req_size   <= '0;
      r_req_addr   <= '0;
      r_req_wdata  <= '0;
      r_htrans     <= T_IDLE;
      r_hwdata     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_req_write <= req_write;
        r_req_size  <= req_size;
        r_req_addr  <= req_addr;
        r_req_wdata <= req_wdata;
      end
      r_req_ready  <= (w_state_nxt == ST_IDLE);
      r_htrans     <= (w_state_nxt == ST_ADDR) ? T_NONSEQ : T_IDLE;
      r_hwdata     <= (w_state_nxt == ST_DATA && r_req_write) ? r_req_wdata : '0;
      r_resp_valid <= w_fire;
      r_resp_err   <= w_fire_err;
      r_resp_rdata <= (w_fire && !w_fire_err && !r_req_write) ? H_rdata : '0;
    end
  end

`ifdef AHB_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_wait_cnt;
  logic          w_busy;

  assign w_busy    = (r_state != ST_IDLE);
  // Fires on the edge that completes the TIMEOUT_CYC-th consecutive wait.
  assign w_timeout = w_busy && !H_ready && (r_wait_cnt == TO_LAST);

  always_ff @(posedge H_clk) begin
    if (H_reset || !w_busy || H_ready || (w_state_nxt != r_state))
      r_wait_cnt <= '0;
    else
      r_wait_cnt <= r_wait_cnt + 1'b1;
  end
`else
  // No watchdog: never time out. TIMEOUT_CYC is referenced only so the
  // parameter stays part of the interface in this build.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign H_addr     = r_req_addr;
  assign H_trans    = r_htrans;
  assign H_write    = r_req_write;
  assign H_size     = r_req_size;
  assign H_wdata    = r_hwdata;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: table-driven bench for ahb_lite_master. The bench acts
// as the AHB slave, pushes the expected response of each request into a
// scoreboard queue when the request is driven, and pops/compares it whenever
// resp_valid is seen. Hand-written sequences cover reset mid-transfer and,
// with AHB_MST_TIMEOUT_EN, the watchdog (DUT built with TIMEOUT_CYC=8).
module tb_ahb_lite_master;
  import ahb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          H_clk = 1'b0;
  logic          H_reset;
  logic          req_valid, req_ready, req_write;
  logic [2:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] H_addr;
  logic [1:0]    H_trans;
  logic          H_write;
  logic [2:0]    H_size;
  logic [DW-1:0] H_wdata;
  logic          H_ready;
  logic [1:0]    H_resp;
  logic [DW-1:0] H_rdata;

  ahb_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .H_clk(H_clk), .H_reset(H_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .H_addr(H_addr), .H_trans(H_trans), .H_write(H_write), .H_size(H_size),
    .H_wdata(H_wdata), .H_ready(H_ready), .H_resp(H_resp), .H_rdata(H_rdata)
  );

  always #5 H_clk = ~H_clk;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } resp_t;

  // emode: 0 OKAY, 1 two-cycle ERROR, 2 ERROR with H_ready=1 (violation)
  typedef struct {
    logic          wr;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] sdata;
    int            aw;
    int            dw;
    int            retries;
    int            emode;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  resp_t sb_q[$];
  vec_t  vt[9];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_resp  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and sample #1 later; any response is scoreboarded here.
  task automatic step();
    resp_t e;
    @(posedge H_clk);
    #1;
    if (resp_valid === 1'b1) begin
      n_resp++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        e = sb_q.pop_front();
        chk("resp_err", resp_err, e.err);
        chk("resp_rdata", resp_rdata, e.rdata);
      end
    end
  endtask

  function automatic vec_t mk(logic wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] sd, int aw, int dw, int rt, int em,
                              logic xe, logic [31:0] xr);
    vec_t v;
    v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd; v.sdata = sd;
    v.aw = aw; v.dw = dw; v.retries = rt; v.emode = em;
    v.exp_err = xe; v.exp_rdata = xr;
    return v;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_H_trans"}, H_trans, T_IDLE);
    chk({tag, "_H_addr"}, H_addr, 0);
    chk({tag, "_H_write"}, H_write, 0);
    chk({tag, "_H_size"}, H_size, 0);
    chk({tag, "_H_wdata"}, H_wdata, 0);
  endtask

  task automatic run_txn(input vec_t v);
    int    w = 0;
    int    r0;
    resp_t e;
    while (req_ready !== 1'b1 && w < 20) begin step(); w++; end
    if (w >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL req_ready_wait: got req_ready=%b expected 1 within 20 cycles", req_ready);
    end
    req_valid = 1'b1; req_write = v.wr; req_size = v.size;
    req_addr = v.addr; req_wdata = v.wdata;
    H_ready = 1'b1; H_resp = OKAY;
    e.err = v.exp_err; e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    step();
    req_valid = 1'b0; req_wdata = $urandom;
    r0 = n_resp;
    for (int rt = 0; rt <= v.retries; rt++) begin
      for (int a = 0; a < v.aw; a++) begin
        H_ready = 1'b0;
        chk("addr_wait_trans", H_trans, T_NONSEQ);
        chk("addr_wait_addr", H_addr, v.addr);
        step();
      end
      chk("addr_trans", H_trans, T_NONSEQ);
      chk("addr_addr", H_addr, v.addr);
      chk("addr_write", H_write, v.wr);
      chk("addr_size", H_size, v.size);
      chk("busy_req_ready", req_ready, 0);
      H_ready = 1'b1;
      step();
      for (int d = 0; d < v.dw; d++) begin
        chk("data_wait_trans", H_trans, T_IDLE);
        if (v.wr) chk("data_wait_wdata", H_wdata, v.wdata);
        H_ready = 1'b0; H_resp = OKAY; H_rdata = $urandom;
        step();
      end
      chk("data_trans", H_trans, T_IDLE);
      if (v.wr) chk("data_wdata", H_wdata, v.wdata);
      if (rt < v.retries) begin
        H_ready = 1'b0; H_resp = (rt % 2 == 1) ? SPLIT : RETRY; H_rdata = $urandom;
        step();
        chk("rtry2_trans", H_trans, T_IDLE);
        H_ready = 1'b1;
        step();
        H_resp = OKAY;
      end else if (v.emode == 1) begin
        H_ready = 1'b0; H_resp = ERROR; H_rdata = $urandom;
        step();
        chk("err2_trans", H_trans, T_IDLE);
        H_ready = 1'b1;
        step();
      end else begin
        H_ready = 1'b1; H_resp = (v.emode == 2) ? ERROR : OKAY;
        H_rdata = v.sdata;
        step();
      end
    end
    H_ready = 1'b1; H_resp = OKAY; H_rdata = $urandom;
    chk("resp_valid", resp_valid, 1);
    chk("resp_count", n_resp - r0, 1);
    chk("resp_req_ready", req_ready, 1);
    chk("resp_trans", H_trans, T_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "bench timed out");
  end

  initial begin
    int cnt;
    resp_t e;
    vec_t  rv;
    vt[0] = mk(0, SZ_WORD, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    vt[1] = mk(1, SZ_WORD, 32'h20, 32'h1234_5678, 32'hFFFF_FFFF, 0, 3, 0, 0, 0, 32'h0);
    vt[2] = mk(0, SZ_WORD, 32'h30, 32'h0, 32'h0BAD_F00D, 2, 0, 0, 0, 0, 32'h0BAD_F00D);
    vt[3] = mk(0, SZ_WORD, 32'h40, 32'h0, 32'h1111_1111, 0, 0, 0, 1, 1, 32'h0);
    vt[4] = mk(0, SZ_WORD, 32'h50, 32'h0, 32'hA5A5_A5A5, 0, 0, 2, 0, 0, 32'hA5A5_A5A5);
    vt[5] = mk(1, SZ_HALF, 32'h62, 32'h0000_CAFE, 32'h2222_2222, 0, 1, 0, 1, 1, 32'h0);
    vt[6] = mk(0, 3'b111, 32'h71, 32'h0, 32'h0000_0055, 0, 0, 0, 0, 0, 32'h0000_0055);
    vt[7] = mk(1, SZ_BYTE, 32'h73, 32'h0000_005A, 32'h3333_3333, 1, 2, 1, 0, 0, 32'h0);
    vt[8] = mk(0, SZ_WORD, 32'h84, 32'h0, 32'h4444_4444, 0, 0, 0, 2, 1, 32'h0);

    H_reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
    req_addr = '0; req_wdata = '0; H_ready = 1'b1; H_resp = OKAY; H_rdata = '0;
    step(); step();
    chk_reset_vals("reset");
    H_reset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_txn(vt[i]);

    // Reset while waiting in the data phase: request dropped, no response.
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD;
    req_addr = 32'h0000_0088; req_wdata = 32'h7777_7777;
    step();
    req_valid = 1'b0; H_ready = 1'b1;
    step();
    chk("mid_data_wdata", H_wdata, 32'h7777_7777);
    H_ready = 1'b0;
    step();
    H_reset = 1'b1;
    step();
    chk_reset_vals("mid_reset");
    H_reset = 1'b0; H_ready = 1'b1;
    repeat (4) step();
    run_txn(vt[0]);

`ifdef AHB_MST_TIMEOUT_EN
    // Watchdog: slave stalls forever in the data phase.
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_addr = 32'h90;
    e.err = 1'b1; e.rdata = '0;
    sb_q.push_back(e);
    step();
    req_valid = 1'b0; H_ready = 1'b1;
    step();
    H_ready = 1'b0; H_rdata = 32'hFEED_FACE;
    cnt = 0;
    while (resp_valid !== 1'b1 && cnt < 40) begin step(); cnt++; end
    chk("timeout_cycles", cnt, 8);
    chk("timeout_trans", H_trans, T_IDLE);
    chk("timeout_req_ready", req_ready, 1);
    H_ready = 1'b1;
    step();
    rv = vt[4];
    run_txn(rv);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
